// File: rtl/chess_link_pkg.sv
// Shared definitions for the board-to-board move link (rx now, tx later):
// frame marker, payload bit layout and the receive framer states.
package chess_link_pkg;
  localparam logic [7:0] LINK_HDR_BYTE    = 8'hA5;
  localparam int unsigned LINK_FRAME_BYTES = 3;

  localparam int unsigned PAY_PICK    = 7;
  localparam int unsigned PAY_TURN    = 6;
  localparam int unsigned PAY_POS_MSB = 5;

  typedef enum bit [1:0] {HUNT, GOT_HDR, GOT_PAY} LINK_RX_STATE_T;
endpackage

// File: rtl/move_link_rx_if.sv
// Byte input from uart_rx and the opponent-facing levels toward game logic.
interface move_link_rx_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       oponent_pick;
  logic [5:0] oponent_position;
  logic       begin_turn;
  logic       set_player;
  logic       frame_ok;
  logic       frame_err;

  modport slave (
    input  rx_data, rx_valid,
    output oponent_pick, oponent_position, begin_turn, set_player, frame_ok, frame_err
  );
  modport master (
    output rx_data, rx_valid,
    input  oponent_pick, oponent_position, begin_turn, set_player, frame_ok, frame_err
  );
endinterface

// File: rtl/link_watchdog.sv
// Inter-byte idle timer: one-cycle expired pulse after TIMEOUT_CYCLES-1 idle
// clocks while enabled; a kick in the expiry cycle wins over the timeout.
module link_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 650_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic kick,
  output logic expired
);
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] SAT  = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] r_cnt;

  // Parks one past LAST so expiry can fire only once even if enable lingers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                r_cnt <= '0;
    else if (kick || !enable)  r_cnt <= '0;
    else if (r_cnt != SAT)     r_cnt <= r_cnt + 1'b1;
  end

  assign expired = enable && !kick && (r_cnt == LAST);
endmodule

// File: rtl/move_link_rx.sv
// Move-link receive framer: HDR, payload, ~payload -> held opponent levels.
// MOVE_LINK_CHECK_EN enables check-byte validation; otherwise byte2 is only consumed.
module move_link_rx
  import chess_link_pkg::*;
#(
  parameter int unsigned CLK_HZ         = 65_000_000,
  parameter int unsigned TIMEOUT_CYCLES = CLK_HZ / 100,
  parameter logic [7:0]  HDR_BYTE       = LINK_HDR_BYTE
) (
  input  logic           clk,
  input  logic           rst_n,
  move_link_rx_if.slave  link
);
  LINK_RX_STATE_T r_state, w_state_nxt;
  logic [7:0] r_pay;
  logic       r_pick, r_turn, r_set, r_ok, r_err;
  logic [5:0] r_pos;
  logic       w_commit, w_err, w_latch, w_expired, w_chk_bad, w_wd_en;

  assign w_wd_en = (r_state != HUNT);

  link_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .enable  (w_wd_en),
    .kick    (link.rx_valid),
    .expired (w_expired)
  );

`ifdef MOVE_LINK_CHECK_EN
  assign w_chk_bad = (link.rx_data != ~r_pay);
`else
  assign w_chk_bad = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= HUNT;
    else        r_state <= w_state_nxt;
  end

  // A header value inside the payload slot is data; only a failed check byte resyncs.
  always_comb begin
    w_state_nxt = r_state;
    w_commit    = 1'b0;
    w_err       = 1'b0;
    w_latch     = 1'b0;
    if (link.rx_valid) begin
      case (r_state)
        HUNT:    if (link.rx_data == HDR_BYTE) w_state_nxt = GOT_HDR;
        GOT_HDR: begin
          w_latch     = 1'b1;
          w_state_nxt = GOT_PAY;
        end
        GOT_PAY: begin
          if (w_chk_bad) begin
            w_err       = 1'b1;
            w_state_nxt = (link.rx_data == HDR_BYTE) ? GOT_HDR : HUNT;
          end else begin
            w_commit    = 1'b1;
            w_state_nxt = HUNT;
          end
        end
        default: w_state_nxt = HUNT;
      endcase
    end else if (w_expired) begin
      w_err       = 1'b1;
      w_state_nxt = HUNT;
    end
  end

  // begin_turn resets high to match the consumer's prev_begin_turn.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pay  <= '0;
      r_pick <= 1'b0;
      r_turn <= 1'b1;
      r_pos  <= '0;
      r_set  <= 1'b0;
      r_ok   <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_ok  <= w_commit;
      r_err <= w_err;
      if (w_latch) r_pay <= link.rx_data;
      if (w_commit) begin
        r_pick <= r_pay[PAY_PICK];
        r_turn <= r_pay[PAY_TURN];
        r_pos  <= r_pay[PAY_POS_MSB:0];
        r_set  <= 1'b1;
      end
    end
  end

  assign link.oponent_pick     = r_pick;
  assign link.oponent_position = r_pos;
  assign link.begin_turn       = r_turn;
  assign link.set_player       = r_set;
  assign link.frame_ok         = r_ok;
  assign link.frame_err        = r_err;
endmodule

// File: tb/tb_move_link_rx.sv
// Bench for move_link_rx: directed vector table, timeout/reset sequences and
// randomized frames against a queue-based framing model.
module tb_move_link_rx;
  import chess_link_pkg::*;

  localparam int unsigned TO  = 50;
  localparam logic [7:0]  HDR = LINK_HDR_BYTE;
`ifdef MOVE_LINK_CHECK_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  move_link_rx_if lnk();

  move_link_rx #(.TIMEOUT_CYCLES(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .link  (lnk)
  );

  int n_chk = 0;
  int n_err = 0;

  // Reference model: bytes of the frame in progress plus idle clocks since the last byte.
  logic [7:0] fb[$];
  int         m_idle;
  bit         m_pick, m_turn, m_set, m_ok, m_err;
  logic [5:0] m_pos;

  task automatic model_reset();
    fb.delete();
    m_idle = 0;
    m_pick = 1'b0; m_turn = 1'b1; m_pos = '0; m_set = 1'b0;
    m_ok = 1'b0; m_err = 1'b0;
  endtask

  task automatic model_step(input bit v, input logic [7:0] d);
    logic [7:0] p;
    m_ok = 1'b0;
    m_err = 1'b0;
    if (v) begin
      m_idle = 0;
      if (fb.size() == 0) begin
        if (d == HDR) fb.push_back(d);
      end else if (fb.size() == 1) begin
        fb.push_back(d);
      end else begin
        p = fb[1];
        fb.delete();
        if (!CK || (d == (p ^ 8'hFF))) begin
          m_ok = 1'b1;
          m_pick = p[7];
          m_turn = p[6];
          m_pos  = p[5:0];
          m_set  = 1'b1;
        end else begin
          m_err = 1'b1;
          if (d == HDR) fb.push_back(d);
        end
      end
    end else if (fb.size() != 0) begin
      m_idle++;
      if (m_idle == TO) begin
        m_err = 1'b1;
        fb.delete();
      end
    end
  endtask

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_outs(input string tag, input bit ok, input bit err, input bit pick,
                          input bit turn, input logic [5:0] pos, input bit set);
    chk({tag, ".frame_ok"},   8'(lnk.frame_ok),         8'(ok));
    chk({tag, ".frame_err"},  8'(lnk.frame_err),        8'(err));
    chk({tag, ".pick"},       8'(lnk.oponent_pick),     8'(pick));
    chk({tag, ".begin_turn"}, 8'(lnk.begin_turn),       8'(turn));
    chk({tag, ".position"},   8'(lnk.oponent_position), 8'(pos));
    chk({tag, ".set_player"}, 8'(lnk.set_player),       8'(set));
  endtask

  task automatic chk_model(input string tag);
    chk_outs(tag, m_ok, m_err, m_pick, m_turn, m_pos, m_set);
    chk({tag, ".ok_err_excl"}, 8'(lnk.frame_ok & lnk.frame_err), 8'h00);
  endtask

  // One clock: drive at negedge, model follows the posedge, DUT sampled 1ns later.
  task automatic cyc(input bit v, input logic [7:0] d);
    @(negedge clk);
    lnk.rx_valid = v;
    lnk.rx_data  = d;
    @(posedge clk);
    model_step(v, d);
    #1;
  endtask

  typedef struct {
    bit v; logic [7:0] d;
    bit ok; bit err; bit pick; bit turn; logic [5:0] pos; bit set;
  } vec_t;

  function automatic vec_t mk(bit v, logic [7:0] d, bit ok, bit err, bit pick, bit turn,
                              logic [5:0] pos, bit set);
    vec_t t;
    t.v = v; t.d = d; t.ok = ok; t.err = err;
    t.pick = pick; t.turn = turn; t.pos = pos; t.set = set;
    return t;
  endfunction

  vec_t tv[$];

  initial begin
    logic [7:0] bq[$];
    logic [7:0] p;
    int kind, gap, r;
    bit sp, st, ss;
    logic [5:0] spos;

    lnk.rx_valid = 1'b0;
    lnk.rx_data  = '0;
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk_outs("reset", 0, 0, 0, 1, 6'h00, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back strobes; expectations written after the byte's clock edge.
    tv.push_back(mk(1, 8'hA5, 0, 0, 0, 1, 6'h00, 0));
    tv.push_back(mk(1, 8'h8B, 0, 0, 0, 1, 6'h00, 0));
    tv.push_back(mk(1, 8'h74, 1, 0, 1, 0, 6'h0B, 1));
    tv.push_back(mk(1, 8'hA5, 0, 0, 1, 0, 6'h0B, 1));
    tv.push_back(mk(1, 8'h12, 0, 0, 1, 0, 6'h0B, 1));
    tv.push_back(CK ? mk(1, 8'h00, 0, 1, 1, 0, 6'h0B, 1) : mk(1, 8'h00, 1, 0, 0, 0, 6'h12, 1));
    tv.push_back(CK ? mk(1, 8'hA5, 0, 0, 1, 0, 6'h0B, 1) : mk(1, 8'hA5, 0, 0, 0, 0, 6'h12, 1));
    tv.push_back(CK ? mk(1, 8'h12, 0, 0, 1, 0, 6'h0B, 1) : mk(1, 8'h12, 0, 0, 0, 0, 6'h12, 1));
    tv.push_back(mk(1, 8'hED, 1, 0, 0, 0, 6'h12, 1));
    tv.push_back(mk(1, 8'h00, 0, 0, 0, 0, 6'h12, 1));
    tv.push_back(mk(1, 8'hFF, 0, 0, 0, 0, 6'h12, 1));
    tv.push_back(mk(1, 8'hA5, 0, 0, 0, 0, 6'h12, 1));
    tv.push_back(mk(1, 8'h40, 0, 0, 0, 0, 6'h12, 1));
    tv.push_back(mk(1, 8'hBF, 1, 0, 0, 1, 6'h00, 1));
    tv.push_back(mk(1, 8'hA5, 0, 0, 0, 1, 6'h00, 1));
    tv.push_back(mk(1, 8'hA5, 0, 0, 0, 1, 6'h00, 1));
    tv.push_back(mk(1, 8'h5A, 1, 0, 1, 0, 6'h25, 1));
    tv.push_back(mk(1, 8'hA5, 0, 0, 1, 0, 6'h25, 1));
    tv.push_back(mk(1, 8'h12, 0, 0, 1, 0, 6'h25, 1));
    tv.push_back(CK ? mk(1, 8'hA5, 0, 1, 1, 0, 6'h25, 1) : mk(1, 8'hA5, 1, 0, 0, 0, 6'h12, 1));
    tv.push_back(CK ? mk(1, 8'h8B, 0, 0, 1, 0, 6'h25, 1) : mk(1, 8'h8B, 0, 0, 0, 0, 6'h12, 1));
    tv.push_back(CK ? mk(1, 8'h74, 1, 0, 1, 0, 6'h0B, 1) : mk(1, 8'h74, 0, 0, 0, 0, 6'h12, 1));
    tv.push_back(CK ? mk(0, 8'h00, 0, 0, 1, 0, 6'h0B, 1) : mk(0, 8'h00, 0, 0, 0, 0, 6'h12, 1));

    foreach (tv[i]) begin
      cyc(tv[i].v, tv[i].d);
      chk_outs($sformatf("vec%0d", i), tv[i].ok, tv[i].err, tv[i].pick, tv[i].turn,
               tv[i].pos, tv[i].set);
    end

    // Timeout: header then silence; then 3F,C0 must not be taken as payload/check.
    sp = lnk.oponent_pick; st = lnk.begin_turn; spos = lnk.oponent_position; ss = lnk.set_player;
    cyc(1, HDR);
    for (int k = 1; k <= TO + 1; k++) begin
      cyc(0, 8'h00);
      chk($sformatf("timeout.err@%0d", k), 8'(lnk.frame_err), 8'((k == int'(TO)) ? 1 : 0));
    end
    cyc(1, 8'h3F);
    cyc(1, 8'hC0);
    chk_outs("after_timeout", 0, 0, sp, st, spos, ss);

    // Reset mid-frame: partial frame discarded, outputs return to reset values.
    cyc(1, 8'hA5);
    cyc(1, 8'h8B);
    @(negedge clk);
    lnk.rx_valid = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk_outs("midreset.async", 0, 0, 0, 1, 6'h00, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1, 8'h74);
    chk_outs("midreset.after", 0, 0, 0, 1, 6'h00, 0);
    cyc(0, 8'h00);
    chk_outs("midreset.idle", 0, 0, 0, 1, 6'h00, 0);

    // Randomized frames, bad checks, garbage, stalls and resyncs against the model.
    for (int f = 0; f < 300; f++) begin
      kind = $urandom_range(0, 9);
      p = 8'($urandom);
      bq.delete();
      case (kind)
        0, 1, 2, 3: bq = '{HDR, p, p ^ 8'hFF};
        4:          bq = '{HDR, p, (p ^ 8'hFF) ^ (8'h01 << $urandom_range(0, 7))};
        5:          bq = '{p};
        6:          bq = '{HDR, HDR, 8'h5A};
        7:          bq = '{HDR, p};
        8:          bq = '{HDR, p, HDR};
        default:    bq = '{HDR};
      endcase
      foreach (bq[b]) begin
        cyc(1, bq[b]);
        chk_model($sformatf("rnd%0d.b%0d", f, b));
        r = $urandom_range(0, 19);
        if (kind == 7 && b == 1) gap = TO + 2;
        else if (r == 0)         gap = $urandom_range(TO - 3, TO + 3);
        else if (r < 10)         gap = 0;
        else                     gap = $urandom_range(1, 3);
        for (int g = 0; g < gap; g++) begin
          cyc(0, 8'h00);
          chk_model($sformatf("rnd%0d.gap", f));
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
